// File: rtl/protobuf_pkg.sv
// protobuf_pkg: shared protobuf wire types, constants and key composition
package protobuf_pkg;

  typedef logic [2:0] proto_wireType;
  typedef logic [3:0] proto_fieldNumber;

  localparam proto_wireType wiretype_varint  = 3'd0;
  localparam proto_wireType wiretype_fixed64 = 3'd1;
  localparam proto_wireType wiretype_len     = 3'd2;
  localparam int MAX_VARINT_BYTES = 10;

  typedef enum logic [2:0] {IDLE, KEY, VARINT, FIXED64, PAYLOAD} enc_state_t;

  // Inverse of slicing a key byte into field number and wire type.
  function automatic logic [7:0] compose_key(input proto_fieldNumber fn, input proto_wireType wt);
    return {1'b0, fn, wt};
  endfunction

endpackage

// File: rtl/protobuf_varint_serializer.sv
// protobuf_varint_serializer: emits a loaded 64-bit value as varint bytes, LSB group first
module protobuf_varint_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [63:0] i_value,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_last,
  input  logic        i_ready
);
  logic [63:0] r_val;
  logic        r_act;
  logic        w_more;
  assign w_more  = |r_val[63:7];
  assign o_valid = r_act;
  assign o_data  = {w_more, r_val[6:0]};
  assign o_last  = !w_more;
  // Shift out one 7-bit group per accepted byte; a 64-bit value needs at most 10 groups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
      r_act <= 1'b0;
    end else if (i_load) begin
      r_val <= i_value;
      r_act <= 1'b1;
    end else if (r_act && i_ready) begin
      r_val <= r_val >> 7;
      r_act <= w_more;
    end
  end
endmodule

// File: rtl/protobuf_field_encoder.sv
// protobuf_field_encoder: serialises one protobuf field per accepted descriptor
module protobuf_field_encoder #(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        field_valid,
  output logic        field_ready,
  input  logic [3:0]  field_num,
  input  logic [2:0]  wire_type,
  input  logic [63:0] value,
  input  logic [7:0]  pay_data,
  input  logic        pay_valid,
  output logic        pay_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        err
);
  import protobuf_pkg::*;

  enc_state_t        r_state, w_next;
  proto_wireType     r_wt;
  logic [63:0]       r_val;
  logic [LEN_W-1:0]  r_cnt;
  logic [7:0]        r_out_data, w_data, w_s_data;
  logic              r_out_valid, r_out_last, r_err;
  logic              w_adv, w_bad, w_acc, w_len_nz, w_ld, w_last;
  logic              w_s_valid, w_s_last, w_s_ready;

  assign w_adv       = !r_out_valid || out_ready;
  assign w_bad       = field_num == 4'd0 || wire_type > wiretype_len ||
                       (wire_type == wiretype_len && |value[63:LEN_W]);
  assign field_ready = r_state == IDLE && !rst;
  assign w_acc       = field_valid && field_ready && !w_bad;
  assign w_len_nz    = r_wt == wiretype_len && r_cnt != '0;
  assign pay_ready   = r_state == PAYLOAD && w_adv && r_cnt != '0;
  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign err         = r_err;

  protobuf_varint_serializer u_varint (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_acc && wire_type != wiretype_fixed64),
    .i_value (value),
    .o_valid (w_s_valid),
    .o_data  (w_s_data),
    .o_last  (w_s_last),
    .i_ready (w_s_ready)
  );

  // State register; reset abandons any partial field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and the byte to load into the output register when the slot frees up.
  always_comb begin
    w_next    = r_state;
    w_ld      = 1'b0;
    w_data    = 8'h00;
    w_last    = 1'b0;
    w_s_ready = 1'b0;
    case (r_state)
      IDLE: if (w_acc) begin
        w_next = KEY;
        w_ld   = 1'b1;
        w_data = compose_key(field_num, wire_type);
      end
      KEY: if (w_adv) begin
        w_ld      = 1'b1;
        w_next    = r_wt == wiretype_fixed64 ? FIXED64 : VARINT;
        w_data    = r_wt == wiretype_fixed64 ? r_val[7:0] : w_s_data;
        w_last    = r_wt != wiretype_fixed64 && w_s_last && !w_len_nz;
        w_s_ready = r_wt != wiretype_fixed64;
      end
      VARINT: if (w_adv) begin
        w_ld      = w_s_valid;
        w_s_ready = w_s_valid;
        w_data    = w_s_data;
        w_last    = w_s_last && !w_len_nz;
        w_next    = w_s_valid ? VARINT : (w_len_nz ? PAYLOAD : IDLE);
      end
      FIXED64: if (w_adv) begin
        w_ld   = r_cnt != LEN_W'(8);
        w_data = r_val[7:0];
        w_last = r_cnt == LEN_W'(7);
        w_next = r_cnt == LEN_W'(8) ? IDLE : FIXED64;
      end
      PAYLOAD: begin
        w_ld   = pay_valid && pay_ready;
        w_data = pay_data;
        w_last = r_cnt == LEN_W'(1);
        w_next = w_adv && r_cnt == '0 ? IDLE : PAYLOAD;
      end
    endcase
  end

  // Output register, descriptor capture, fixed64 shifter and byte counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
      r_wt        <= '0;
      r_val       <= '0;
      r_cnt       <= '0;
    end else begin
      r_err <= field_valid && field_ready && w_bad;
      if (w_ld) begin
        r_out_data  <= w_data;
        r_out_last  <= w_last;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      if (w_acc) begin
        r_wt  <= wire_type;
        r_val <= value;
        r_cnt <= wire_type == wiretype_len ? value[LEN_W-1:0] : '0;
      end else if (w_ld && r_wt == wiretype_fixed64) begin
        r_val <= r_val >> 8;
        r_cnt <= r_cnt + 1'b1;
      end else if (w_ld && r_state == PAYLOAD) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_protobuf_field_encoder.sv
// tb_protobuf_field_encoder: directed self-checking bench for the field encoder
module tb_protobuf_field_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        field_valid = 1'b0;
  logic        field_ready;
  logic [3:0]  field_num = '0;
  logic [2:0]  wire_type = '0;
  logic [63:0] value = '0;
  logic [7:0]  pay_data = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        err;

  int nchk = 0;
  int nerr = 0;
  logic       rnd = 1'b0;
  logic [7:0] pay_q[$];
  logic [7:0] cap[$];
  logic       capl[$];
  logic [7:0] eq[$];
  logic       pst = 1'b0;
  logic       pl;
  logic [7:0] pd;

  protobuf_field_encoder #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .field_valid(field_valid), .field_ready(field_ready),
    .field_num(field_num), .wire_type(wire_type), .value(value),
    .pay_data(pay_data), .pay_valid(pay_valid), .pay_ready(pay_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Records transfers and checks that stalled bytes hold steady.
  always @(negedge clk) begin
    if (rst) pst = 1'b0;
    else begin
      if (pst) check("stall", 64'({out_valid, out_last, out_data}), 64'({1'b1, pl, pd}));
      if (out_valid && out_ready) begin
        cap.push_back(out_data);
        capl.push_back(out_last);
      end
      pst = out_valid && !out_ready;
      pd  = out_data;
      pl  = out_last;
    end
  end

  task automatic feed();
    logic f;
    forever begin
      @(negedge clk);
      f = pay_valid && pay_ready;
      @(posedge clk);
      #1;
      if (f && pay_q.size() > 0) void'(pay_q.pop_front());
      pay_valid = pay_q.size() > 0;
      pay_data  = pay_q.size() > 0 ? pay_q[0] : 8'h00;
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic send(input logic [3:0] fn, input logic [2:0] wt, input logic [63:0] v, input logic good);
    @(posedge clk);
    #1;
    field_valid = 1'b1;
    field_num = fn;
    wire_type = wt;
    value = v;
    @(negedge clk);
    check("rdy", 64'(field_ready), 1);
    @(posedge clk);
    #1;
    field_valid = 1'b0;
    @(negedge clk);
    if (good) begin
      check("lat_valid", 64'(out_valid), 1);
      check("lat_key", 64'(out_data), 64'({1'b0, fn, wt}));
    end else begin
      check("err", 64'(err), 1);
      check("err_ov", 64'(out_valid), 0);
      check("err_rdy", 64'(field_ready), 1);
      @(negedge clk);
      check("err_pulse", 64'(err), 0);
      check("err_ov2", 64'(out_valid), 0);
    end
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 400 && cap.size() < n; i++) @(negedge clk);
    @(posedge clk);
  endtask

  task automatic cmp(input string tag);
    check({tag, "_n"}, 64'(cap.size()), 64'(eq.size()));
    for (int i = 0; i < eq.size() && i < cap.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 64'(cap[i]), 64'(eq[i]));
      check($sformatf("%s_l%0d", tag, i), 64'(capl[i]), 64'(i == eq.size() - 1));
    end
    cap.delete();
    capl.delete();
  endtask

  initial begin
    fork
      feed();
      drive_ready();
    join_none
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 64'(out_valid), 0);
    check("rst_od", 64'(out_data), 0);
    check("rst_ol", 64'(out_last), 0);
    check("rst_err", 64'(err), 0);
    check("rst_fr", 64'(field_ready), 0);
    check("rst_pr", 64'(pay_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_fr", 64'(field_ready), 1);

    send(4'd1, 3'd0, 64'd150, 1'b1);
    wait_done(3);
    eq = '{8'h08, 8'h96, 8'h01};
    cmp("v150");

    pay_q = '{8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h67};
    send(4'd2, 3'd2, 64'd7, 1'b1);
    wait_done(9);
    eq = '{8'h12, 8'h07, 8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h67};
    cmp("testing");
    check("idle_pr", 64'(pay_ready), 0);

    send(4'd2, 3'd2, 64'd0, 1'b1);
    wait_done(2);
    eq = '{8'h12, 8'h00};
    cmp("len0");

    send(4'd3, 3'd1, 64'h0102030405060708, 1'b1);
    wait_done(9);
    eq = '{8'h19, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
    cmp("fix64");

    rnd = 1'b1;
    send(4'd15, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(11);
    eq = '{8'h78};
    repeat (9) eq.push_back(8'hFF);
    eq.push_back(8'h01);
    cmp("vmax");
    rnd = 1'b0;
    repeat (2) @(posedge clk);

    send(4'd1, 3'd5, 64'd3, 1'b0);
    send(4'd0, 3'd0, 64'd3, 1'b0);
    send(4'd4, 3'd2, 64'h1_0000, 1'b0);
    check("rej_none", 64'(cap.size()), 0);

    pay_q = '{8'h74, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h67};
    send(4'd2, 3'd2, 64'd7, 1'b1);
    for (int i = 0; i < 400 && cap.size() < 5; i++) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_ov", 64'(out_valid), 0);
    check("mid_od", 64'(out_data), 0);
    check("mid_pr", 64'(pay_ready), 0);
    check("mid_err", 64'(err), 0);
    check("mid_fr", 64'(field_ready), 0);
    pay_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rel_fr", 64'(field_ready), 1);
    cap.delete();
    capl.delete();
    send(4'd1, 3'd0, 64'd1, 1'b1);
    wait_done(2);
    eq = '{8'h08, 8'h01};
    cmp("post_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
